// File: rtl/regfile_sb.sv
// Multi-read, single-write register file with registered write-first read ports
// and a pending-write scoreboard. Define ZERO_REG_EN to hard-wire register 0 to zero.
module regfile_sb #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [WIDTH-1:0]  read_data1,
  output logic [WIDTH-1:0]  read_data2,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic [ADDR_W:0]   pending_cnt
);

`ifdef ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;
  logic             wr_ok;
  logic             rs_ok;
  logic [WIDTH-1:0] rd1_nxt;
  logic [WIDTH-1:0] rd2_nxt;

  assign wr_ok = write_enable && !(ZeroReg && (write_addr == '0));
  assign rs_ok = reserve_en   && !(ZeroReg && (reserve_addr == '0));

  // Clear first, then set: a same-address reserve overrides the commit.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[write_addr] = 1'b0;
    if (rs_ok) busy_nxt[reserve_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_comb begin
    if (ZeroReg && (read_addr1 == '0))
      rd1_nxt = '0;
    else if (write_enable && (write_addr == read_addr1))
      rd1_nxt = write_data;
    else
      rd1_nxt = regs[read_addr1];

    if (ZeroReg && (read_addr2 == '0))
      rd2_nxt = '0;
    else if (write_enable && (write_addr == read_addr2))
      rd2_nxt = write_data;
    else
      rd2_nxt = regs[read_addr2];
  end

  assign busy1 = busy[read_addr1] && !(ZeroReg && (read_addr1 == '0));
  assign busy2 = busy[read_addr2] && !(ZeroReg && (read_addr2 == '0));
  assign stall = read_enable && (busy1 || busy2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy        <= '0;
      pending_cnt <= '0;
      read_data1  <= '0;
      read_data2  <= '0;
    end else begin
      if (wr_ok)
        regs[write_addr] <= write_data;
      busy        <= busy_nxt;
      pending_cnt <= cnt_nxt;
      if (read_enable) begin
        read_data1 <= rd1_nxt;
        read_data2 <= rd2_nxt;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios plus random traffic,
// checked against an array-based reference model.
module tb_regfile_sb;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

`ifdef ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              read_enable;
  logic [ADDR_W-1:0] read_addr1, read_addr2;
  logic [WIDTH-1:0]  read_data1, read_data2;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [WIDTH-1:0]  write_data;
  logic              reserve_en;
  logic [ADDR_W-1:0] reserve_addr;
  logic              busy1, busy2, stall;
  logic [ADDR_W:0]   pending_cnt;

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .read_enable(read_enable), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .busy1(busy1), .busy2(busy2), .stall(stall), .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] regs_m [DEPTH];
  bit               busy_m [DEPTH];
  logic [WIDTH-1:0] rd1_m, rd2_m;
  logic [2*WIDTH-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pop_m();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += busy_m[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] model_read(input int a, input bit we, input int wa,
                                                  input logic [WIDTH-1:0] wd);
    if (ZeroReg && a == 0) return '0;
    if (we && wa == a) return wd;
    return regs_m[a];
  endfunction

  // Read ports are registered: compare on every falling edge against the
  // value the model predicted for the preceding rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2*WIDTH-1:0] e;
      e = exp_q.pop_front();
      chk("read_data1", {16'h0, read_data1}, {16'h0, e[2*WIDTH-1:WIDTH]});
      chk("read_data2", {16'h0, read_data2}, {16'h0, e[WIDTH-1:0]});
    end
  end

  task automatic cycle(input bit re, input int a1, input int a2,
                       input bit we, input int wa, input logic [WIDTH-1:0] wd,
                       input bit rs, input int ra);
    bit eb1, eb2;
    @(negedge clk);
    read_enable  = re;
    read_addr1   = ADDR_W'(a1);
    read_addr2   = ADDR_W'(a2);
    write_enable = we;
    write_addr   = ADDR_W'(wa);
    write_data   = wd;
    reserve_en   = rs;
    reserve_addr = ADDR_W'(ra);
    #1;
    eb1 = busy_m[a1];
    eb2 = busy_m[a2];
    chk("busy1", {31'h0, busy1}, {31'h0, eb1});
    chk("busy2", {31'h0, busy2}, {31'h0, eb2});
    chk("stall", {31'h0, stall}, {31'h0, re && (eb1 || eb2)});
    chk("pending_cnt", {28'h0, pending_cnt}, 32'(pop_m()));
    if (re) begin
      rd1_m = model_read(a1, we, wa, wd);
      rd2_m = model_read(a2, we, wa, wd);
    end
    if (we && !(ZeroReg && wa == 0)) regs_m[wa] = wd;
    if (we) busy_m[wa] = 1'b0;
    if (rs && !(ZeroReg && ra == 0)) busy_m[ra] = 1'b1;
    exp_q.push_back({rd1_m, rd2_m});
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    read_enable = 0; write_enable = 0; reserve_en = 0;
    #2 rst = 1'b0;
    #1;
    chk("rst read_data1", {16'h0, read_data1}, 32'h0);
    chk("rst read_data2", {16'h0, read_data2}, 32'h0);
    chk("rst pending_cnt", {28'h0, pending_cnt}, 32'h0);
    chk("rst busy1", {31'h0, busy1}, 32'h0);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin regs_m[i] = '0; busy_m[i] = 1'b0; end
    rd1_m = '0; rd2_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    read_enable = 0; write_enable = 0; reserve_en = 0;
    read_addr1 = '0; read_addr2 = '0; write_addr = '0; write_data = '0; reserve_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin regs_m[i] = '0; busy_m[i] = 1'b0; end
    rd1_m = '0; rd2_m = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init read_data1", {16'h0, read_data1}, 32'h0);
    chk("init pending_cnt", {28'h0, pending_cnt}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Write then read, and hold with read_enable low
    cycle(0, 0, 0, 1, 5, 16'h1234, 0, 0);
    cycle(1, 5, 0, 0, 0, '0, 0, 0);
    idle();
    chk("r5 read", {16'h0, read_data1}, 32'h1234);
    cycle(0, 3, 3, 1, 5, 16'h7777, 0, 0);
    chk("r5 hold", {16'h0, read_data1}, 32'h1234);

    // Bypass on both ports
    cycle(1, 2, 2, 1, 2, 16'hA5A5, 0, 0);
    idle();
    chk("bypass rd1", {16'h0, read_data1}, 32'hA5A5);
    chk("bypass rd2", {16'h0, read_data2}, 32'hA5A5);

    // Hazard on r4, committed while being read
    cycle(0, 0, 0, 0, 0, '0, 1, 4);
    cycle(1, 0, 4, 1, 4, 16'h0042, 0, 0);
    chk("hazard busy2", {31'h0, busy2}, 32'h1);
    chk("hazard stall", {31'h0, stall}, 32'h1);
    chk("hazard pend", {28'h0, pending_cnt}, 32'h1);
    cycle(1, 0, 4, 0, 0, '0, 0, 0);
    chk("commit busy2", {31'h0, busy2}, 32'h0);
    chk("commit stall", {31'h0, stall}, 32'h0);
    chk("commit pend", {28'h0, pending_cnt}, 32'h0);
    chk("commit data", {16'h0, read_data2}, 32'h0042);

    // Same-address reserve+commit on busy r6, then reserve r1 + commit r6
    cycle(0, 0, 0, 0, 0, '0, 1, 6);
    cycle(0, 6, 0, 1, 6, 16'h0006, 1, 6);
    cycle(1, 6, 0, 0, 0, '0, 0, 0);
    chk("r6 busy kept", {31'h0, busy1}, 32'h1);
    chk("r6 pend", {28'h0, pending_cnt}, 32'h1);
    cycle(0, 1, 6, 1, 6, 16'h0066, 1, 1);
    idle();
    chk("swap pend", {28'h0, pending_cnt}, 32'h1);
    cycle(0, 0, 0, 1, 1, 16'h0001, 0, 0);

    // Register 0 behaviour
    cycle(0, 0, 0, 1, 0, 16'hFFFF, 1, 0);
    cycle(1, 0, 0, 0, 0, '0, 0, 0);
    idle();
`ifdef ZERO_REG_EN
    chk("r0 data", {16'h0, read_data1}, 32'h0);
    chk("r0 busy1", {31'h0, busy1}, 32'h0);
    chk("r0 pend", {28'h0, pending_cnt}, 32'h0);
`else
    chk("r0 data", {16'h0, read_data1}, 32'hFFFF);
    cycle(0, 0, 0, 0, 0, '0, 0, 0);
    chk("r0 busy1", {31'h0, busy1}, 32'h1);
    chk("r0 pend", {28'h0, pending_cnt}, 32'h1);
`endif

    // Reset mid-stream loses r3 and pending reservations
    cycle(0, 0, 0, 1, 3, 16'hBEEF, 1, 7);
    do_reset();
    cycle(1, 3, 3, 0, 0, '0, 0, 0);
    idle();
    chk("r3 after rst", {16'h0, read_data1}, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      cycle($urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
            $urandom_range(0, 2) != 0, $urandom_range(0, DEPTH-1), WIDTH'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH-1));
    end
    idle();
    @(negedge clk);
    #1;
    chk("queue drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read, single-write register file with an integrated pending-write scoreboard for the pipelined RISC core.
- Decode issues register reads and reserves the destination register.
- Write-back commits data and releases the reservation.
- The block flags operand hazards so decode can stall.
- Read data is registered on the rising edge, with write-first bypass.

Parameters:
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers; must be a power of two, at least 2
- ADDR_W, 3, address width; must equal log2(DEPTH)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- read_enable  input  1  capture both read ports this cycle
- read_addr1  input  ADDR_W  read port 1 address
- read_addr2  input  ADDR_W  read port 2 address
- read_data1  output  WIDTH  registered read port 1 data
- read_data2  output  WIDTH  registered read port 2 data
- write_enable  input  1  commit write_data to write_addr
- write_addr  input  ADDR_W  commit address
- write_data  input  WIDTH  commit data
- reserve_en  input  1  mark reserve_addr as pending
- reserve_addr  input  ADDR_W  destination being reserved
- busy1  output  1  read_addr1 currently pending (combinational)
- busy2  output  1  read_addr2 currently pending (combinational)
- stall  output  1  read_enable and (busy1 or busy2) (combinational)
- pending_cnt  output  ADDR_W+1  number of set busy bits (registered)

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers, read_data1/2, busy bits and pending_cnt go to 0 immediately;
  - no tri-state outputs.
- Write: on posedge with write_enable=1, reg[write_addr] <= write_data.
- Read, latency 1:
  - on posedge with read_enable=1, read_dataN <= reg[read_addrN];
  - with read_enable=0, read_dataN holds its value.
- Bypass: if write_enable and read_enable are both 1 and write_addr==read_addrN, read_dataN <= write_data (new data, not the old content).
- Scoreboard: one busy bit per register.
  - reserve_en sets busy[reserve_addr].
  - write_enable clears busy[write_addr].
  - Same cycle, same address: the set wins, because a younger producer replaced the older one.
  - Different addresses: both take effect.
  - Reserving an already-busy register keeps it busy; pending_cnt does not change.
  - A write to a non-busy register is legal and leaves the bit clear.
- Hazard outputs:
  - busyN = busy[read_addrN], taken from the registered bits only.
  - A commit in the current cycle does not clear busyN until the next cycle; the bypass covers the data path.
  - stall is asserted only when read_enable=1.
  - read_data still updates when stall=1; decode is responsible for discarding it.
- pending_cnt:
  - tracks the population count of the next busy vector, registered;
  - range 0..DEPTH, no wrap;
  - net change per cycle is -1, 0 or +1.
- Reset mid-operation:
  - pending reservations are dropped;
  - any write in flight is lost;
  - no write occurs while rst=0.

Optional Feature:
Macro ZERO_REG_EN.
- When defined:
  - register 0 always reads as 0, including via bypass;
  - writes to address 0 are discarded;
  - reserve of address 0 is ignored, so busy[0] is always 0 and address 0 never counts in pending_cnt;
  - busyN is 0 when read_addrN=0.
- When undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then read all addresses: rst=0 mid-stream after writing 16'hBEEF to r3 → read_data1/2=0, busy=0, pending_cnt=0 asynchronously; a later read of r3 returns 0.
- Write then read: write r5=16'h1234; next cycle read_addr1=5 with read_enable=1 → read_data1=16'h1234 one cycle later; with read_enable=0 the output holds.
- Bypass: in the same cycle write r2=16'hA5A5 and read both ports at r2 → both read_data=16'hA5A5 after that edge.
- Hazard: reserve r4 → next cycle read_addr2=4 with read_enable=1 gives busy2=1, stall=1, pending_cnt=1; commit r4=16'h0042 → following cycle busy2=0, stall=0, pending_cnt=0.
- Simultaneous events on r6: reserve r6 and commit r6 together while r6 is busy → busy[6] stays 1, pending_cnt unchanged. Reserve r1 and commit r6 together → pending_cnt unchanged (+1 and -1).
- ZERO_REG_EN build: write r0=16'hFFFF and reserve r0 → read_data1=0, busy1=0, pending_cnt=0. Without the macro → read_data1=16'hFFFF, busy1=1.
